// File: rtl/ps2_key_event_decoder.sv
// Folds PS/2 E0/F0 prefixes into key events, buffers them in a first-word fall-through FIFO and tracks the held key.
// Optional: define KEY_REPEAT_FILTER_EN to discard typematic repeats of the currently held key.
module ps2_key_event_decoder #(
  parameter int EV_DEPTH = 8,
  parameter int CNT_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  kb_data,
  input  logic                        kb_ready,
  output logic                        kb_nextdata_n,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [7:0]                  ev_code,
  output logic                        ev_ext,
  output logic                        ev_break,
  output logic [$clog2(EV_DEPTH):0]   ev_level,
  output logic                        ev_overflow,
  output logic [CNT_W-1:0]            press_cnt,
  output logic                        held_valid,
  output logic [7:0]                  held_code,
  output logic                        held_ext
);

  localparam int AW = $clog2(EV_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(EV_DEPTH);

  typedef enum logic [1:0] {IDLE, POP, DECODE} state_t;

  state_t     state_q, state_d;
  logic [7:0] byte_q;
  logic       pend_ext, pend_brk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && kb_ready) byte_q <= kb_data;
    end
  end

  // The pop strobe sits one cycle after the latch so IDLE never re-samples a stale kb_ready.
  always_comb begin
    state_d       = state_q;
    kb_nextdata_n = 1'b1;
    case (state_q)
      IDLE:    if (kb_ready) state_d = POP;
      POP: begin
        kb_nextdata_n = 1'b0;
        state_d       = DECODE;
      end
      DECODE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic is_decode, is_e0, is_f0, is_err, ev_fire, match_held, is_repeat, push;

  always_comb begin
    is_decode  = (state_q == DECODE);
    is_e0      = (byte_q == 8'hE0);
    is_f0      = (byte_q == 8'hF0);
    is_err     = (byte_q == 8'h00) || (byte_q == 8'hFF);
    ev_fire    = is_decode && !is_e0 && !is_f0 && !is_err;
    match_held = held_valid && (pend_ext == held_ext) && (byte_q == held_code);
`ifdef KEY_REPEAT_FILTER_EN
    is_repeat  = ev_fire && !pend_brk && match_held;
`else
    is_repeat  = 1'b0;
`endif
    push       = ev_fire && !is_repeat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_ext <= 1'b0;
      pend_brk <= 1'b0;
    end else if (is_decode) begin
      if (is_e0) begin
        pend_ext <= 1'b1;
      end else if (is_f0) begin
        pend_brk <= 1'b1;
      end else begin
        pend_ext <= 1'b0;
        pend_brk <= 1'b0;
      end
    end
  end

  // Held-key and counter updates happen even when the FIFO drops the event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_cnt  <= '0;
      held_valid <= 1'b0;
      held_code  <= 8'h00;
      held_ext   <= 1'b0;
    end else if (push && !pend_brk) begin
      press_cnt  <= press_cnt + CNT_W'(1);
      held_valid <= 1'b1;
      held_code  <= byte_q;
      held_ext   <= pend_ext;
    end else if (push && pend_brk && match_held) begin
      held_valid <= 1'b0;
    end
  end

  logic [9:0]    mem [EV_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, wr_en;
  logic [9:0]    head;

  assign ev_valid = (ev_level != '0);
  assign full     = (ev_level == FULL_LVL);
  assign pop      = ev_valid && ev_ready;
  assign wr_en    = push && (!full || pop);
  assign head     = mem[rd_ptr];
  assign {ev_ext, ev_break, ev_code} = ev_valid ? head : 10'h000;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {pend_ext, pend_brk, byte_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ev_level    <= '0;
      ev_overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   ev_level <= ev_level + LW'(1);
        2'b01:   ev_level <= ev_level - LW'(1);
        default: ev_level <= ev_level;
      endcase
      if (push && full && !pop) ev_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Scoreboard bench for ps2_key_event_decoder: a byte-FIFO model feeds the DUT, a reference model predicts events.
// Honours KEY_REPEAT_FILTER_EN the same way the design does.
module tb_ps2_key_event_decoder;

  localparam int EV_DEPTH = 8;
  localparam int CNT_W    = 8;
  localparam int LW       = $clog2(EV_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    kb_data;
  logic          kb_ready;
  logic          kb_nextdata_n;
  logic          ev_valid;
  logic          ev_ready;
  logic [7:0]    ev_code;
  logic          ev_ext;
  logic          ev_break;
  logic [LW-1:0] ev_level;
  logic          ev_overflow;
  logic [CNT_W-1:0] press_cnt;
  logic          held_valid;
  logic [7:0]    held_code;
  logic          held_ext;

  ps2_key_event_decoder #(.EV_DEPTH(EV_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .kb_data(kb_data), .kb_ready(kb_ready),
    .kb_nextdata_n(kb_nextdata_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break), .ev_level(ev_level),
    .ev_overflow(ev_overflow), .press_cnt(press_cnt), .held_valid(held_valid),
    .held_code(held_code), .held_ext(held_ext)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int bytes_sent = 0;
  int pop_pulses = 0;

  logic [7:0] kb_q[$];
  logic [9:0] exp_q[$];

  logic       m_ext = 1'b0, m_brk = 1'b0, m_hv = 1'b0, m_he = 1'b0, m_ovf = 1'b0;
  logic [7:0] m_hc = 8'h00;
  logic [CNT_W-1:0] m_cnt = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model of one decoded byte; drop marks an event the full FIFO must discard.
  task automatic modelByte(input logic [7:0] b, input bit drop);
    logic repeat_hit;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'h00 || b == 8'hFF) begin
      m_ext = 1'b0; m_brk = 1'b0;
    end else begin
      repeat_hit = 1'b0;
`ifdef KEY_REPEAT_FILTER_EN
      repeat_hit = !m_brk && m_hv && (m_he == m_ext) && (m_hc == b);
`endif
      if (!repeat_hit) begin
        if (drop) m_ovf = 1'b1;
        else exp_q.push_back({m_ext, m_brk, b});
        if (!m_brk) begin
          m_cnt = m_cnt + CNT_W'(1);
          m_hv = 1'b1; m_hc = b; m_he = m_ext;
        end else if (m_hv && m_he == m_ext && m_hc == b) begin
          m_hv = 1'b0;
        end
      end
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit drop);
    kb_q.push_back(b);
    bytes_sent++;
    modelByte(b, drop);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (kb_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) checkOutput("kb_drain_timeout", 32'(kb_q.size()), 32'd0);
    repeat (3) @(posedge clk);
  endtask

  task automatic checkState(input string tag);
    @(negedge clk);
    $display("[TB] state check %s", tag);
    checkOutput({tag, ".level"}, 32'(ev_level), 32'(exp_q.size()));
    checkOutput({tag, ".valid"}, 32'(ev_valid), 32'(exp_q.size() != 0));
    checkOutput({tag, ".ovf"}, 32'(ev_overflow), 32'(m_ovf));
    checkOutput({tag, ".cnt"}, 32'(press_cnt), 32'(m_cnt));
    checkOutput({tag, ".hv"}, 32'(held_valid), 32'(m_hv));
    checkOutput({tag, ".hc"}, 32'(held_code), 32'(m_hc));
    checkOutput({tag, ".he"}, 32'(held_ext), 32'(m_he));
    checkOutput({tag, ".pops"}, 32'(pop_pulses), 32'(bytes_sent));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    @(posedge clk); #1 ev_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1 ev_ready = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".left"}, 32'(exp_q.size()), 32'd0);
    checkOutput({tag, ".empty"}, 32'(ev_valid), 32'd0);
  endtask

  // Keyboard FIFO model: pops on each low strobe and presents the next byte.
  initial begin
    logic prev_low = 1'b0;
    kb_ready = 1'b0;
    kb_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (!kb_nextdata_n) begin
        pop_pulses++;
        if (prev_low) checkOutput("pop_width", 32'd2, 32'd1);
        if (kb_q.size() != 0) void'(kb_q.pop_front());
      end
      prev_low = !kb_nextdata_n;
      kb_ready = (kb_q.size() != 0);
      kb_data  = (kb_q.size() != 0) ? kb_q[0] : 8'h00;
    end
  end

  // Consumer side of the scoreboard: every accepted head event is compared.
  initial begin
    logic [9:0] expv;
    forever begin
      @(negedge clk);
      if (!rst && ev_valid && ev_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("ev_unexpected", {22'd0, ev_ext, ev_break, ev_code}, 32'h3FF);
        end else begin
          expv = exp_q.pop_front();
          checkOutput("ev_event", {22'd0, ev_ext, ev_break, ev_code}, {22'd0, expv});
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    ev_ready = 1'b0;
    repeat (2) @(posedge clk);
    checkState("reset");
    checkOutput("reset.nextdata_n", 32'(kb_nextdata_n), 32'd1);
    checkOutput("reset.head", {22'd0, ev_ext, ev_break, ev_code}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // make then break of a plain key
    applyStimulus(8'h15, 0);
    waitIdle();
    checkState("make15");
    applyStimulus(8'hF0, 0); applyStimulus(8'h15, 0);
    waitIdle();
    checkState("break15");
    drain("t1");

    // extended key, then error code flushing a pending prefix
    applyStimulus(8'hE0, 0); applyStimulus(8'h75, 0);
    waitIdle();
    checkState("make_e075");
    applyStimulus(8'hE0, 0); applyStimulus(8'hF0, 0); applyStimulus(8'h75, 0);
    applyStimulus(8'hE0, 0); applyStimulus(8'hFF, 0); applyStimulus(8'h1A, 0);
    waitIdle();
    checkState("break_e075");
    drain("t2");

    // fill to full, then a push coinciding with a pop
    for (int i = 0; i < EV_DEPTH; i++) applyStimulus(8'h30 + 8'(i), 0);
    waitIdle();
    checkState("full");
    applyStimulus(8'h38, 0);
    n = 0;
    while (kb_nextdata_n !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("strobe_timeout", 32'(n >= 50), 32'd0);
    @(posedge clk); #1 ev_ready = 1'b1;
    @(posedge clk); #1 ev_ready = 1'b0;
    waitIdle();
    checkState("push_pop_full");
    drain("t3");

    // overflow: ninth make is dropped
    for (int i = 0; i < EV_DEPTH + 1; i++) applyStimulus(8'h40 + 8'(i), i == EV_DEPTH);
    waitIdle();
    checkState("overflow");
    drain("t4");

    // typematic repeats of one key
    applyStimulus(8'h1C, 0); applyStimulus(8'h1C, 0); applyStimulus(8'h1C, 0);
    applyStimulus(8'hF0, 0); applyStimulus(8'h1C, 0);
    waitIdle();
    checkState("repeat");
    drain("t5");

    // asynchronous reset with a prefix pending and events buffered
    applyStimulus(8'h16, 0); applyStimulus(8'hE0, 0);
    waitIdle();
    @(posedge clk); #3 rst = 1'b1;
    #1;
    checkOutput("arst.nextdata_n", 32'(kb_nextdata_n), 32'd1);
    checkOutput("arst.valid", 32'(ev_valid), 32'd0);
    checkOutput("arst.level", 32'(ev_level), 32'd0);
    checkOutput("arst.ovf", 32'(ev_overflow), 32'd0);
    checkOutput("arst.cnt", 32'(press_cnt), 32'd0);
    checkOutput("arst.held", {22'd0, held_valid, held_ext, held_code}, 32'd0);
    checkOutput("arst.head", {22'd0, ev_ext, ev_break, ev_code}, 32'd0);
    exp_q.delete();
    m_ext = 1'b0; m_brk = 1'b0; m_hv = 1'b0; m_he = 1'b0; m_hc = 8'h00; m_ovf = 1'b0; m_cnt = '0;
    @(posedge clk); #1 rst = 1'b0;
    applyStimulus(8'h74, 0);
    waitIdle();
    checkState("after_reset");
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
